// File: rtl/control_unit_pipe.sv
// Decode/control for the 5-stage RV32 core: D-stage decode, the ID/EX control register,
// load-use stall, taken-branch flush and a multi-cycle MUL hold.
module control_unit_pipe #(
    parameter int unsigned ENABLE_M    = 1,
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned ALUCTRL_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          InstrD_i,
    input  logic                 ValidD_i,
    input  logic                 PCSrcE_i,
    output logic [2:0]           ImmSrcD_o,
    output logic                 IllegalD_o,
    output logic                 RegWriteE_o,
    output logic [1:0]           ResultSrcE_o,
    output logic                 MemWriteE_o,
    output logic [ALUCTRL_W-1:0] ALUControlE_o,
    output logic                 ALUSrcE_o,
    output logic                 ALUSrcAE_o,
    output logic                 BranchE_o,
    output logic [2:0]           BranchTypeE_o,
    output logic                 JumpE_o,
    output logic                 JalrE_o,
    output logic [4:0]           RdE_o,
    output logic [4:0]           Rs1E_o,
    output logic [4:0]           Rs2E_o,
    output logic                 StallF_o,
    output logic                 StallD_o,
    output logic                 FlushD_o,
    output logic                 MulBusyE_o
);

    localparam int unsigned CntW = $clog2(MUL_LATENCY);
    localparam logic [CntW-1:0] CntInit = CntW'(MUL_LATENCY - 1);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [ALUCTRL_W-1:0] AluAdd  = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] AluSub  = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] AluAnd  = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] AluOr   = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] AluXor  = ALUCTRL_W'(4);
    localparam logic [ALUCTRL_W-1:0] AluSlt  = ALUCTRL_W'(5);
    localparam logic [ALUCTRL_W-1:0] AluSltu = ALUCTRL_W'(6);
    localparam logic [ALUCTRL_W-1:0] AluSll  = ALUCTRL_W'(7);
    localparam logic [ALUCTRL_W-1:0] AluSrl  = ALUCTRL_W'(8);
    localparam logic [ALUCTRL_W-1:0] AluSra  = ALUCTRL_W'(9);
    localparam logic [ALUCTRL_W-1:0] AluMul  = ALUCTRL_W'(10);

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b100;

    typedef struct packed {
        logic                 reg_write;
        logic [1:0]           result_src;
        logic                 mem_write;
        logic [ALUCTRL_W-1:0] alu_ctrl;
        logic                 alu_src;
        logic                 alu_src_a;
        logic                 branch;
        logic [2:0]           branch_type;
        logic                 jump;
        logic                 jalr;
        logic                 is_mul;
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
    } ctl_t;

    typedef enum logic [0:0] {StIdle, StMulBusy} state_e;

    function automatic logic [ALUCTRL_W-1:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? AluSub : AluAdd;
            3'b001:  return AluSll;
            3'b010:  return AluSlt;
            3'b011:  return AluSltu;
            3'b100:  return AluXor;
            3'b101:  return alt ? AluSra : AluSrl;
            3'b110:  return AluOr;
            default: return AluAnd;
        endcase
    endfunction

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    logic       legal, use_rs1, use_rs2, dec_valid, load_use;
    ctl_t       dec, ctl_d, ctl_q;
    state_e     state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;

    assign opcode = InstrD_i[6:0];
    assign rd     = InstrD_i[11:7];
    assign funct3 = InstrD_i[14:12];
    assign rs1    = InstrD_i[19:15];
    assign rs2    = InstrD_i[24:20];
    assign funct7 = InstrD_i[31:25];

    always_comb begin
        dec       = '0;
        legal     = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        ImmSrcD_o = ImmI;
        case (opcode)
            OpLoad: begin
                legal          = (funct3 == 3'b010);
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b01;
                dec.alu_src    = 1'b1;
                use_rs1        = 1'b1;
            end
            OpStore: begin
                legal         = (funct3 == 3'b010);
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                ImmSrcD_o     = ImmS;
            end
            OpR: begin
                dec.reg_write = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                if (funct7 == 7'b0000000) begin
                    legal        = 1'b1;
                    dec.alu_ctrl = alu_of(funct3, 1'b0);
                end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    legal        = 1'b1;
                    dec.alu_ctrl = alu_of(funct3, 1'b1);
                end else if (funct7 == 7'b0000001 && funct3 == 3'b000 && ENABLE_M != 0) begin
                    legal        = 1'b1;
                    dec.alu_ctrl = AluMul;
                    dec.is_mul   = 1'b1;
                end
            end
            OpImm: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                use_rs1       = 1'b1;
                // instr[30] only selects sra for shifts; addi with imm[10] set stays an add
                if (funct3 == 3'b001) begin
                    legal        = (funct7 == 7'b0000000);
                    dec.alu_ctrl = AluSll;
                end else if (funct3 == 3'b101) begin
                    legal        = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    dec.alu_ctrl = funct7[5] ? AluSra : AluSrl;
                end else begin
                    legal        = 1'b1;
                    dec.alu_ctrl = alu_of(funct3, 1'b0);
                end
            end
            OpBranch: begin
                legal           = (funct3 != 3'b010) && (funct3 != 3'b011);
                dec.branch      = 1'b1;
                dec.branch_type = funct3;
                dec.alu_ctrl    = AluSub;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
                ImmSrcD_o       = ImmB;
            end
            OpJal: begin
                legal          = 1'b1;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
                dec.jump       = 1'b1;
                ImmSrcD_o      = ImmJ;
            end
            OpJalr: begin
                legal          = (funct3 == 3'b000);
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
                dec.jump       = 1'b1;
                dec.jalr       = 1'b1;
                dec.alu_src    = 1'b1;
                use_rs1        = 1'b1;
            end
            OpLui: begin
                legal          = 1'b1;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b11;
                ImmSrcD_o      = ImmU;
            end
            OpAuipc: begin
                legal         = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_src_a = 1'b1;
                ImmSrcD_o     = ImmU;
            end
            default: legal = 1'b0;
        endcase
        // Unused register fields are zeroed so forwarding never matches stale bits
        dec.rd        = dec.reg_write ? rd : 5'd0;
        dec.reg_write = dec.reg_write & (rd != 5'd0);
        dec.rs1       = use_rs1 ? rs1 : 5'd0;
        dec.rs2       = use_rs2 ? rs2 : 5'd0;
    end

    assign IllegalD_o = ValidD_i & ~legal;
    assign dec_valid  = ValidD_i & legal;
    assign load_use   = (ctl_q.result_src == 2'b01) & ctl_q.reg_write & dec_valid &
                        ((use_rs1 & (ctl_q.rd == rs1)) | (use_rs2 & (ctl_q.rd == rs2)));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ctl_d      = ctl_q;
        StallF_o   = 1'b0;
        StallD_o   = 1'b0;
        FlushD_o   = 1'b0;
        MulBusyE_o = (state_q == StMulBusy);
        if (MulBusyE_o) begin
            // PCSrcE cannot legally coincide with a MUL in EX, so it is ignored here
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            cnt_d    = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) state_d = StIdle;
        end else if (PCSrcE_i) begin
            FlushD_o = 1'b1;
            ctl_d    = '0;
        end else if (load_use) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            ctl_d    = '0;
        end else begin
            ctl_d = dec_valid ? dec : '0;
            if (dec_valid && dec.is_mul) begin
                state_d = StMulBusy;
                cnt_d   = CntInit;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
        end
    end

    assign RegWriteE_o   = ctl_q.reg_write;
    assign ResultSrcE_o  = ctl_q.result_src;
    assign MemWriteE_o   = ctl_q.mem_write;
    assign ALUControlE_o = ctl_q.alu_ctrl;
    assign ALUSrcE_o     = ctl_q.alu_src;
    assign ALUSrcAE_o    = ctl_q.alu_src_a;
    assign BranchE_o     = ctl_q.branch;
    assign BranchTypeE_o = ctl_q.branch_type;
    assign JumpE_o       = ctl_q.jump;
    assign JalrE_o       = ctl_q.jalr;
    assign RdE_o         = ctl_q.rd;
    assign Rs1E_o        = ctl_q.rs1;
    assign Rs2E_o        = ctl_q.rs2;

endmodule
